breakout_game_ctrl: RTL and testbench

// Central game sequencer for Breakout. Merges the per-column bounce requests
// (moveU/D/L/R) from all block-column modules with wall and paddle hits, and

---
 rtl/breakout_game_ctrl.sv | 148 ++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: merges block/wall/paddle bounces into the ball
// direction, runs serve/play/lock/over/win, counts lives and sums column scores.
module breakout_game_ctrl #(
    parameter int NUM_COLS    = 20,
    parameter int COL_SCORE_W = 6,
    parameter int SCORE_W     = 10,
    parameter int MAX_SCORE   = 660,
    parameter int LIVES       = 3,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            frame_tick,
    input  logic                            start,
    input  logic [NUM_COLS-1:0]             hit_u,
    input  logic [NUM_COLS-1:0]             hit_d,
    input  logic [NUM_COLS-1:0]             hit_l,
    input  logic [NUM_COLS-1:0]             hit_r,
    input  logic                            wall_l,
    input  logic                            wall_r,
    input  logic                            wall_t,
    input  logic                            paddle_hit,
    input  logic                            ball_miss,
    input  logic [NUM_COLS*COL_SCORE_W-1:0] col_scores,
    output logic                            dir_x,
    output logic                            dir_y,
    output logic                            ball_hold,
    output logic                            bounce,
    output logic [2:0]                      lives,
    output logic [SCORE_W-1:0]              score_total,
    output logic [2:0]                      state
);

    localparam int LW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

    typedef enum logic [2:0] {
        S_SERVE = 3'd0,
        S_PLAY  = 3'd1,
        S_LOCK  = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_dir_x, w_dir_x_nxt;
    logic               r_dir_y, w_dir_y_nxt;
    logic               r_hold, w_hold_nxt;
    logic               r_bounce, w_bounce_nxt;
    logic [2:0]         r_lives, w_lives_nxt;
    logic [LW-1:0]      r_lock, w_lock_nxt;
    logic [SCORE_W-1:0] r_score, w_score_sum;
    logic               w_blk_v, w_blk_h;
    logic [2:0]         w_lives_dec;

    assign w_blk_v     = (|hit_u) | (|hit_d);
    assign w_blk_h     = (|hit_l) | (|hit_r);
    assign w_lives_dec = r_lives - 3'd1;

    always_comb begin
        w_score_sum = '0;
        for (int unsigned k = 0; k < NUM_COLS; k++) begin
            w_score_sum = w_score_sum + SCORE_W'(col_scores[k*COL_SCORE_W +: COL_SCORE_W]);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_dir_x_nxt  = r_dir_x;
        w_dir_y_nxt  = r_dir_y;
        w_bounce_nxt = 1'b0;
        w_lives_nxt  = r_lives;
        w_lock_nxt   = r_lock;
        case (r_state)
            S_SERVE: begin
                if (start) begin
                    w_state_nxt = S_PLAY;
                    w_dir_x_nxt = 1'b1;
                    w_dir_y_nxt = 1'b0;
                end
            end
            S_PLAY, S_LOCK: begin
                if (ball_miss) begin
                    w_lives_nxt = w_lives_dec;
                    w_state_nxt = (w_lives_dec == 3'd0) ? S_OVER : S_SERVE;
                end else if (r_score == SCORE_W'(MAX_SCORE)) begin
                    w_state_nxt = S_WIN;
                end else begin
                    if (r_state == S_PLAY && (w_blk_v || w_blk_h)) begin
                        if (|hit_u)      w_dir_y_nxt = 1'b0;
                        else if (|hit_d) w_dir_y_nxt = 1'b1;
                        if (|hit_l)      w_dir_x_nxt = 1'b0;
                        else if (|hit_r) w_dir_x_nxt = 1'b1;
                        w_bounce_nxt = 1'b1;
                        w_lock_nxt   = LW'(LOCK_FRAMES);
                        w_state_nxt  = S_LOCK;
                    end else if (r_state == S_LOCK) begin
                        if (r_lock == '0)    w_state_nxt = S_PLAY;
                        else if (frame_tick) w_lock_nxt  = r_lock - LW'(1);
                    end
                    // Walls and paddle are applied last so they override a block on the same axis.
                    if (wall_l)     w_dir_x_nxt = 1'b1;
                    if (wall_r)     w_dir_x_nxt = 1'b0;
                    if (wall_t)     w_dir_y_nxt = 1'b1;
                    if (paddle_hit) w_dir_y_nxt = 1'b0;
                end
            end
            S_OVER, S_WIN: begin
                if (start) begin
                    w_lives_nxt = 3'(LIVES);
                    w_state_nxt = S_SERVE;
                end
            end
            default: w_state_nxt = S_SERVE;
        endcase
        w_hold_nxt = !(w_state_nxt == S_PLAY || w_state_nxt == S_LOCK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_SERVE;
            r_dir_x  <= 1'b1;
            r_dir_y  <= 1'b0;
            r_hold   <= 1'b1;
            r_bounce <= 1'b0;
            r_lives  <= 3'(LIVES);
            r_lock   <= '0;
            r_score  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_dir_x  <= w_dir_x_nxt;
            r_dir_y  <= w_dir_y_nxt;
            r_hold   <= w_hold_nxt;
            r_bounce <= w_bounce_nxt;
            r_lives  <= w_lives_nxt;
            r_lock   <= w_lock_nxt;
            r_score  <= w_score_sum;
        end
    end

    assign dir_x       = r_dir_x;
    assign dir_y       = r_dir_y;
    assign ball_hold   = r_hold;
    assign bounce      = r_bounce;
    assign lives       = r_lives;
    assign score_total = r_score;
    assign state       = r_state;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed bench for breakout_game_ctrl with hand-computed expectations.
module tb_breakout_game_ctrl;

    localparam int NC = 20;
    localparam int CW = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           frame_tick, start;
    logic [NC-1:0]  hit_u, hit_d, hit_l, hit_r;
    logic           wall_l, wall_r, wall_t, paddle_hit, ball_miss;
    logic [NC*CW-1:0] col_scores;
    logic           dir_x, dir_y, ball_hold, bounce;
    logic [2:0]     lives, state;
    logic [9:0]     score_total;

    int unsigned errors = 0;
    int unsigned checks = 0;

    breakout_game_ctrl #(
        .NUM_COLS(NC), .COL_SCORE_W(CW), .SCORE_W(10),
        .MAX_SCORE(660), .LIVES(3), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .hit_u(hit_u), .hit_d(hit_d), .hit_l(hit_l), .hit_r(hit_r),
        .wall_l(wall_l), .wall_r(wall_r), .wall_t(wall_t),
        .paddle_hit(paddle_hit), .ball_miss(ball_miss), .col_scores(col_scores),
        .dir_x(dir_x), .dir_y(dir_y), .ball_hold(ball_hold), .bounce(bounce),
        .lives(lives), .score_total(score_total), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        frame_tick = 0; start = 0; hit_u = '0; hit_d = '0; hit_l = '0; hit_r = '0;
        wall_l = 0; wall_r = 0; wall_t = 0; paddle_hit = 0; ball_miss = 0;
    endtask

    task automatic exit_lock();
        frame_tick = 1; step();
        chk("lock_cnt1_state", state, 2);
        step();
        chk("lock_cnt0_state", state, 2);
        frame_tick = 0; step();
        chk("lock_exit_state", state, 1);
    endtask

    initial begin
        clear_in();
        col_scores = '0;
        reset = 1;
        #3;
        chk("rst_state", state, 0);
        chk("rst_dir_x", dir_x, 1);
        chk("rst_dir_y", dir_y, 0);
        chk("rst_hold", ball_hold, 1);
        chk("rst_bounce", bounce, 0);
        chk("rst_lives", lives, 3);
        chk("rst_score", score_total, 0);
        step(); step();
        reset = 0;
        step();

        // serve
        start = 1; step(); start = 0;
        chk("t1_state", state, 1);
        chk("t1_dir_x", dir_x, 1);
        chk("t1_dir_y", dir_y, 0);
        chk("t1_hold", ball_hold, 0);

        // block hit, then lockout
        hit_d[5] = 1; step(); hit_d = '0;
        chk("t2_dir_y", dir_y, 1);
        chk("t2_bounce", bounce, 1);
        chk("t2_state", state, 2);
        hit_u[6] = 1; step(); hit_u = '0;
        chk("t2_lock_dir_y", dir_y, 1);
        chk("t2_lock_bounce", bounce, 0);
        chk("t2_lock_state", state, 2);
        exit_lock();

        // wall beats block on same axis
        paddle_hit = 1; step(); paddle_hit = 0;
        chk("t3_paddle_dir_y", dir_y, 0);
        hit_u[3] = 1; wall_t = 1; step(); hit_u = '0; wall_t = 0;
        chk("t3_dir_y", dir_y, 1);
        chk("t3_bounce", bounce, 1);
        chk("t3_state", state, 2);
        wall_r = 1; step(); wall_r = 0;
        chk("t3_lock_wall_dir_x", dir_x, 0);
        exit_lock();

        // lives and game over
        start = 1; step(); start = 0;
        chk("t4_start_in_play", state, 1);
        ball_miss = 1; step(); ball_miss = 0;
        chk("t4_miss1_lives", lives, 2);
        chk("t4_miss1_state", state, 0);
        chk("t4_miss1_hold", ball_hold, 1);
        hit_d[2] = 1; step(); hit_d = '0;
        chk("t4_serve_hit_bounce", bounce, 0);
        chk("t4_serve_hit_dir_y", dir_y, 1);
        chk("t4_serve_hit_state", state, 0);
        start = 1; step(); start = 0;
        chk("t4_reserve_dir_x", dir_x, 1);
        chk("t4_reserve_dir_y", dir_y, 0);
        ball_miss = 1; step(); ball_miss = 0;
        chk("t4_miss2_lives", lives, 1);
        chk("t4_miss2_state", state, 0);
        start = 1; step(); start = 0;
        ball_miss = 1; step(); ball_miss = 0;
        chk("t4_miss3_lives", lives, 0);
        chk("t4_miss3_state", state, 3);
        chk("t4_over_hold", ball_hold, 1);
        start = 1; step(); start = 0;
        chk("t4_restart_lives", lives, 3);
        chk("t4_restart_state", state, 0);

        // scoring and win
        start = 1; step(); start = 0;
        for (int k = 0; k < NC; k++) col_scores[k*CW +: CW] = 6'd33;
        step();
        chk("t5_score_max", score_total, 660);
        chk("t5_state_before_win", state, 1);
        step();
        chk("t5_win_state", state, 4);
        chk("t5_win_hold", ball_hold, 1);
        start = 1; step();
        chk("t5_win_restart_state", state, 0);
        step(); start = 0;
        chk("t5_replay_state", state, 1);
        ball_miss = 1; step(); ball_miss = 0;
        chk("t5_miss_beats_win_state", state, 0);
        chk("t5_miss_beats_win_lives", lives, 2);
        for (int k = 0; k < NC; k++) col_scores[k*CW +: CW] = CW'(k);
        step();
        chk("t5_score_ramp", score_total, 190);

        // async reset mid-lock
        start = 1; step(); start = 0;
        hit_l[0] = 1; step(); hit_l = '0;
        chk("t6_lock_state", state, 2);
        chk("t6_lock_dir_x", dir_x, 0);
        #2 reset = 1;
        #1;
        chk("t6_rst_state", state, 0);
        chk("t6_rst_dir_x", dir_x, 1);
        chk("t6_rst_bounce", bounce, 0);
        chk("t6_rst_hold", ball_hold, 1);
        chk("t6_rst_lives", lives, 3);
        chk("t6_rst_score", score_total, 0);
        step();
        reset = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
